apb_master_arb: RTL and testbench

APB_MASTER_ARB -- requirements
Module: apb_master_arb

---
 rtl/apb_arb_pkg.sv | 16 +
 rtl/apb_rr_arbiter.sv | 43 ++++
 rtl/apb_master_arb.sv | 131 +++++++++++++
 tb/tb_apb_master_arb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the arbitrated APB master.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin requester selection; the search starts one past the last accepted index.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDXW    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    grant_idx
);

  logic [IDXW-1:0] ptr_reg;
  logic            found;
  int              j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_reg) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDXW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (accept && found) begin
      ptr_reg <= (grant_idx == IDXW'(NUM_REQ - 1)) ? '0 : grant_idx + IDXW'(1);
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by NUM_REQ requesters: one transfer in flight, round-robin grant,
// wait-state timeout that completes the transfer with an error.
module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                             pclk,
  input  logic                             prst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  output logic [2:0]                       pprot,
  output logic                             psel,
  output logic                             penable,
  input  logic                             pready,
  input  logic [DATA_WIDTH-1:0]            prdata,
  input  logic                             pslverr
);

  localparam int SW     = DATA_WIDTH / 8;
  localparam int IDXW   = idx_width(NUM_REQ);
  localparam int CLOG_T = $clog2(TIMEOUT_CYC) + 1;
  localparam int WAIT_W = (CLOG_T > 10) ? CLOG_T : 10;

  apb_state_t       state_reg;
  logic [IDXW-1:0]  sel_idx_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;

  logic [NUM_REQ-1:0]    grant;
  logic [IDXW-1:0]       grant_idx;
  logic                  accept;
  logic                  timeout;
  logic                  done;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [SW-1:0]         strb_arr  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign strb_arr[gi]  = req_strb[gi*SW +: SW];
    assign rsp_valid[gi] = done && (sel_idx_reg == IDXW'(gi));
  end

  assign accept    = (state_reg == IDLE) && (|req_valid);
  assign req_ready = accept ? grant : '0;

  // pready takes priority over the timeout in the same ACCESS cycle
  assign timeout   = (wait_cnt_reg == WAIT_W'(TIMEOUT_CYC - 1));
  assign done      = (state_reg == ACCESS) && (pready || timeout);
  assign rsp_err   = (state_reg == ACCESS) && (pready ? pslverr : timeout);
  assign rsp_rdata = ((state_reg == ACCESS) && pready && !pwrite) ? prdata : '0;
  assign pprot     = PPROT_DEFAULT;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_arb (
    .clk       (pclk),
    .rst       (prst),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_reg    <= IDLE;
      sel_idx_reg  <= '0;
      wait_cnt_reg <= '0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      paddr        <= '0;
      pwrite       <= 1'b0;
      pwdata       <= '0;
      pstrb        <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            sel_idx_reg  <= grant_idx;
            wait_cnt_reg <= '0;
            paddr        <= addr_arr[grant_idx];
            pwrite       <= req_write[grant_idx];
            pwdata       <= wdata_arr[grant_idx];
            pstrb        <= req_write[grant_idx] ? strb_arr[grant_idx] : '0;
            psel         <= 1'b1;
            penable      <= 1'b0;
            state_reg    <= SETUP;
          end
        end
        SETUP: begin
          penable   <= 1'b1;
          state_reg <= ACCESS;
        end
        ACCESS: begin
          if (pready || timeout) begin
            psel         <= 1'b0;
            penable      <= 1'b0;
            wait_cnt_reg <= '0;
            state_reg    <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        default: begin
          psel      <= 1'b0;
          penable   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: write, waited read, contention, timeout, slave error, reset.
module tb_apb_master_arb;

  logic        pclk;
  logic        prst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_write;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int total_cnt;
  int pass_cnt;

  apb_master_arb #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .NUM_REQ     (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .pclk      (pclk),
    .prst      (prst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pprot     (pprot),
    .psel      (psel),
    .penable   (penable),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %s: 0x%0h", tag, obs);
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    prst = 1'b1;
    req_valid = '0; req_addr = '0; req_write = '0; req_wdata = '0; req_strb = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    #3;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb", pstrb, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("pprot", pprot, 0);
    repeat (2) @(posedge pclk);
    #2 prst = 1'b0;

    // single write from requester 0, zero wait states
    req_valid = 2'b01; req_addr[31:0] = 32'h10; req_write[0] = 1'b1;
    req_wdata[31:0] = 32'hA5A5_0001; req_strb[3:0] = 4'hF;
    #1 check("wr_req_ready", req_ready, 2'b01);
    check("wr_idle_psel", psel, 0);
    tick();
    req_valid = 2'b00;
    #1 check("wr_setup_psel", psel, 1);
    check("wr_setup_penable", penable, 0);
    check("wr_setup_paddr", paddr, 32'h10);
    check("wr_setup_pwrite", pwrite, 1);
    check("wr_setup_pwdata", pwdata, 32'hA5A5_0001);
    check("wr_setup_pstrb", pstrb, 4'hF);
    check("wr_setup_req_ready", req_ready, 0);
    pready = 1'b1;
    tick();
    #1 check("wr_access_penable", penable, 1);
    check("wr_rsp_valid", rsp_valid, 2'b01);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    tick();
    pready = 1'b0;
    #1 check("wr_idle_psel_after", psel, 0);
    check("wr_idle_paddr_kept", paddr, 32'h10);

    // read from requester 1 with three wait states; strobes must be zeroed
    req_valid = 2'b10; req_addr[63:32] = 32'h20; req_write[1] = 1'b0; req_strb[7:4] = 4'hF;
    #1 check("rd_req_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    #1 check("rd_setup_paddr", paddr, 32'h20);
    check("rd_setup_pwrite", pwrite, 0);
    check("rd_setup_pstrb", pstrb, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      pready = (i == 3);
      prdata = (i == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      #1 check($sformatf("rd_access%0d_penable", i), penable, 1);
      check($sformatf("rd_access%0d_paddr", i), paddr, 32'h20);
      check($sformatf("rd_access%0d_rsp_valid", i), rsp_valid, (i == 3) ? 2'b10 : 2'b00);
      if (i < 3) tick();
    end
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_err", rsp_err, 0);
    tick();
    pready = 1'b0;
    #1 check("rd_idle_psel", psel, 0);

    // contention: both requesters continuously valid
    req_valid = 2'b11; req_write = 2'b11;
    req_addr[31:0] = 32'h100; req_addr[63:32] = 32'h200;
    pready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1 check($sformatf("arb%0d_req_ready", t), req_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      tick();
      #1 check($sformatf("arb%0d_rsp_valid", t), rsp_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("arb%0d_paddr", t), paddr, (t % 2 == 0) ? 32'h100 : 32'h200);
      tick();
    end
    req_valid = 2'b00;
    pready = 1'b0;

    // timeout: requester 0 read, slave never ready
    req_valid = 2'b01; req_write[0] = 1'b0; req_addr[31:0] = 32'h30; prdata = 32'h1234_5678;
    #1 check("to_req_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    for (int k = 1; k <= 16; k++) begin
      #1 check($sformatf("to_access%0d_rsp_valid", k), rsp_valid, (k == 16) ? 2'b01 : 2'b00);
      check($sformatf("to_access%0d_rsp_err", k), rsp_err, (k == 16) ? 1 : 0);
      if (k < 16) tick();
    end
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_psel_last_access", psel, 1);
    tick();
    #1 check("to_psel_after", psel, 0);
    check("to_rsp_valid_after", rsp_valid, 0);

    // slave error on a write from requester 1
    req_valid = 2'b10; req_write[1] = 1'b1; req_addr[63:32] = 32'h40;
    req_wdata[63:32] = 32'h55; req_strb[7:4] = 4'h3;
    #1 check("se_req_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    #1 check("se_setup_pstrb", pstrb, 4'h3);
    check("se_setup_pwdata", pwdata, 32'h55);
    tick();
    pready = 1'b1; pslverr = 1'b1;
    #1 check("se_rsp_valid", rsp_valid, 2'b10);
    check("se_rsp_err", rsp_err, 1);
    tick();
    pready = 1'b0; pslverr = 1'b0;
    #1 check("se_idle_psel", psel, 0);
    check("se_idle_penable", penable, 0);

    // reset during the second ACCESS cycle of a requester 0 transfer
    req_valid = 2'b01; req_write[0] = 1'b1; req_addr[31:0] = 32'h50;
    #1 check("rs_req_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    #1 check("rs_access1_penable", penable, 1);
    tick();
    prst = 1'b1;
    pready = 1'b1;
    #1 check("rs_psel", psel, 0);
    check("rs_penable", penable, 0);
    check("rs_rsp_valid", rsp_valid, 0);
    check("rs_paddr", paddr, 0);
    tick();
    prst = 1'b0;
    pready = 1'b0;
    req_valid = 2'b11;
    #1 check("rs_next_grant", req_ready, 2'b01);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
